// File: rtl/seq_detector_if.sv
// Signal bundle for seq_detector: stimulus side (master) and detector side (slave).
// CNT_W must match the CNT_W of the detector the bundle is connected to.
interface seq_detector_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state;

  modport master (
    output en,
    output din_valid,
    output din,
    output clr_cnt,
    input  match,
    input  match_cnt,
    input  state
  );

  modport slave (
    input  en,
    input  din_valid,
    input  din,
    input  clr_cnt,
    output match,
    output match_cnt,
    output state
  );
endinterface

// File: rtl/seq_detector.sv
// Serial pattern detector with overlap control and a saturating match counter.
// state | meaning
// IDLE  | disabled; fill and hist held at zero
// FILL  | enabled, fewer than W bits of valid history
// ARMED | enabled, W bits of history; every accepted bit can complete a match
// 2'b11 | illegal; recovers to IDLE with history cleared
module seq_detector #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_detector_if.slave   bus
);

  localparam int             FW        = $clog2(W + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(W);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FILL    = 2'b01,
    ARMED   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic [FW-1:0]    fill_inc;
  logic [W-1:0]     hist_q;
  logic [W-1:0]     hist_d;
  logic [W-1:0]     hist_shift;
  logic             det;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next data are derived together so the detect decision
  // sees exactly the fill/history the accepting edge will store.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    hist_d     = hist_q;
    det        = 1'b0;
    hist_shift = {hist_q[W-2:0], bus.din};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    if (state_q == ILLEGAL || !bus.en) begin
      state_d = IDLE;
      fill_d  = '0;
      hist_d  = '0;
    end else begin
      if (bus.din_valid) begin
        fill_d = fill_inc;
        hist_d = hist_shift;
        det    = (fill_inc == FILL_FULL) && (hist_shift == PATTERN);
      end

      if (det && !OVERLAP) begin
        state_d = FILL;
        fill_d  = '0;
        hist_d  = '0;
      end else if (fill_d == FILL_FULL) begin
        state_d = ARMED;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= '0;
      hist_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      match_q <= det;
      // A clear on the same edge as a detection wins over the increment.
      if (bus.clr_cnt) begin
        cnt_q <= '0;
      end else if (det && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.state     = state_q;

endmodule
